// File: rtl/gpr_access_sequencer_if.sv
// Sequencer-side bundle: issue port, GPR file port and execute-unit port.
// master = the sequencer, slave = decode / GPR file / execute unit.
interface gpr_access_sequencer_if #(
    parameter int DW = 8,
    parameter int AW = 3
);
    logic          issue_valid;
    logic          issue_ready;
    logic [1:0]    issue_op;
    logic [AW-1:0] issue_srcA;
    logic [AW-1:0] issue_srcB;
    logic [AW-1:0] issue_dst;

    logic          gpr_readEn;
    logic          gpr_writeEn;
    logic [AW-1:0] gpr_regA_num;
    logic [AW-1:0] gpr_regB_num;
    logic [AW-1:0] gpr_regC_num;
    logic [DW-1:0] gpr_regA_out;
    logic [DW-1:0] gpr_regB_out;
    logic [DW-1:0] gpr_regC_in;
    logic [DW-1:0] gpr_mulHighIn;

    logic [DW-1:0] exec_opA;
    logic [DW-1:0] exec_opB;
    logic          exec_start;
    logic          exec_is_mul;
    logic          exec_done;
    logic [DW-1:0] exec_res_lo;
    logic [DW-1:0] exec_res_hi;

    logic          busy;
    logic          done;
    logic          exec_err;

    modport master (
        input  issue_valid, issue_op, issue_srcA, issue_srcB, issue_dst,
               gpr_regA_out, gpr_regB_out, exec_done, exec_res_lo, exec_res_hi,
        output issue_ready, gpr_readEn, gpr_writeEn, gpr_regA_num, gpr_regB_num,
               gpr_regC_num, gpr_regC_in, gpr_mulHighIn, exec_opA, exec_opB,
               exec_start, exec_is_mul, busy, done, exec_err
    );

    modport slave (
        output issue_valid, issue_op, issue_srcA, issue_srcB, issue_dst,
               gpr_regA_out, gpr_regB_out, exec_done, exec_res_lo, exec_res_hi,
        input  issue_ready, gpr_readEn, gpr_writeEn, gpr_regA_num, gpr_regB_num,
               gpr_regC_num, gpr_regC_in, gpr_mulHighIn, exec_opA, exec_opB,
               exec_start, exec_is_mul, busy, done, exec_err
    );
endinterface

// File: rtl/gpr_access_sequencer.sv
// Single-issue GPR read -> execute -> writeback sequencer.
// IDLE accept op | READ readEn | CAPT latch operands | EXEC wait done/timeout | WRITE writeback+done | FIN done, no write
module gpr_access_sequencer #(
    parameter int DW      = 8,
    parameter int AW      = 3,
    parameter int TIMEOUT = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    gpr_access_sequencer_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_CAPT,
        S_EXEC,
        S_WRITE,
        S_FIN
    } state_t;

    localparam logic [1:0] OP_MUL  = 2'b01;
    localparam logic [1:0] OP_READ = 2'b10;
    localparam logic [1:0] OP_NOP  = 2'b11;
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t        state_q, state_d;
    logic [1:0]    op_q, op_d;
    logic [AW-1:0] srca_q, srca_d;
    logic [AW-1:0] srcb_q, srcb_d;
    logic [AW-1:0] dst_q, dst_d;
    logic [DW-1:0] opa_q, opa_d;
    logic [DW-1:0] opb_q, opb_d;
    logic [DW-1:0] res_lo_q, res_lo_d;
    logic [DW-1:0] res_hi_q, res_hi_d;
    logic [7:0]    cnt_q, cnt_d;
    logic          err_q, err_d;
    logic [AW-1:0] rega_num_q, rega_num_d;
    logic [AW-1:0] regb_num_q, regb_num_d;
    logic [AW-1:0] regc_num_q, regc_num_d;
    logic [DW-1:0] regc_in_q, regc_in_d;
    logic [DW-1:0] mul_high_q, mul_high_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            op_q       <= '0;
            srca_q     <= '0;
            srcb_q     <= '0;
            dst_q      <= '0;
            opa_q      <= '0;
            opb_q      <= '0;
            res_lo_q   <= '0;
            res_hi_q   <= '0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
            rega_num_q <= '0;
            regb_num_q <= '0;
            regc_num_q <= '0;
            regc_in_q  <= '0;
            mul_high_q <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            srca_q     <= srca_d;
            srcb_q     <= srcb_d;
            dst_q      <= dst_d;
            opa_q      <= opa_d;
            opb_q      <= opb_d;
            res_lo_q   <= res_lo_d;
            res_hi_q   <= res_hi_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            rega_num_q <= rega_num_d;
            regb_num_q <= regb_num_d;
            regc_num_q <= regc_num_d;
            regc_in_q  <= regc_in_d;
            mul_high_q <= mul_high_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        srca_d     = srca_q;
        srcb_d     = srcb_q;
        dst_d      = dst_q;
        opa_d      = opa_q;
        opb_d      = opb_q;
        res_lo_d   = res_lo_q;
        res_hi_d   = res_hi_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        rega_num_d = rega_num_q;
        regb_num_d = regb_num_q;
        regc_num_d = regc_num_q;
        regc_in_d  = regc_in_q;
        mul_high_d = mul_high_q;

        // Address/data outputs follow their hold registers except in the cycle that drives them.
        bus.issue_ready   = 1'b0;
        bus.gpr_readEn    = 1'b0;
        bus.gpr_writeEn   = 1'b0;
        bus.gpr_regA_num  = rega_num_q;
        bus.gpr_regB_num  = regb_num_q;
        bus.gpr_regC_num  = regc_num_q;
        bus.gpr_regC_in   = regc_in_q;
        bus.gpr_mulHighIn = mul_high_q;
        bus.exec_start    = 1'b0;
        bus.exec_is_mul   = 1'b0;
        bus.done          = 1'b0;

        case (state_q)
            S_IDLE: begin
                bus.issue_ready = 1'b1;
                if (bus.issue_valid) begin
                    op_d    = bus.issue_op;
                    srca_d  = bus.issue_srcA;
                    srcb_d  = bus.issue_srcB;
                    dst_d   = bus.issue_dst;
                    state_d = (bus.issue_op == OP_NOP) ? S_FIN : S_READ;
                end
            end
            S_READ: begin
                bus.gpr_readEn   = 1'b1;
                bus.gpr_regA_num = srca_q;
                bus.gpr_regB_num = srcb_q;
                rega_num_d       = srca_q;
                regb_num_d       = srcb_q;
                state_d          = S_CAPT;
            end
            S_CAPT: begin
                opa_d = bus.gpr_regA_out;
                opb_d = bus.gpr_regB_out;
                if (op_q == OP_READ) begin
                    state_d = S_FIN;
                end else begin
                    cnt_d   = '0;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                // The counter only advances on non-done cycles, so it is zero exactly in the first EXEC cycle.
                bus.exec_start  = (cnt_q == '0);
                bus.exec_is_mul = (op_q == OP_MUL);
                if (bus.exec_done) begin
                    res_lo_d = bus.exec_res_lo;
                    res_hi_d = bus.exec_res_hi;
                    state_d  = S_WRITE;
                end else if (cnt_q == CNT_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_FIN;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_WRITE: begin
                bus.gpr_writeEn   = 1'b1;
                bus.gpr_regC_num  = dst_q;
                bus.gpr_regC_in   = res_lo_q;
                bus.gpr_mulHighIn = (op_q == OP_MUL) ? res_hi_q : '0;
                regc_num_d        = dst_q;
                regc_in_d         = res_lo_q;
                mul_high_d        = (op_q == OP_MUL) ? res_hi_q : '0;
                bus.done          = 1'b1;
                state_d           = S_IDLE;
            end
            S_FIN: begin
                bus.done = 1'b1;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.exec_opA = opa_q;
    assign bus.exec_opB = opb_q;
    assign bus.busy     = (state_q != S_IDLE);
    assign bus.exec_err = err_q;

endmodule

// File: tb/tb_gpr_access_sequencer.sv
// Randomized scoreboard bench: GPR file and execute-unit models around the sequencer,
// expected per-operation behaviour predicted at issue time and checked on each done pulse.
module tb_gpr_access_sequencer;
    localparam int DW      = 8;
    localparam int AW      = 3;
    localparam int TIMEOUT = 15;
    localparam int NEVER   = -1;

    logic clk = 1'b0;
    logic rst = 1'b1;

    gpr_access_sequencer_if #(.DW(DW), .AW(AW)) bus();

    gpr_access_sequencer #(.DW(DW), .AW(AW), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int lat;
        bit rd;
        int a;
        int b;
        bit st;
        bit wb;
        int c;
        int lo;
        int hi;
        bit err;
        int mulcyc;
        bit chk_op;
        int oa;
        int ob;
    } exp_t;

    exp_t       sc_q[$];
    int         dq[$];
    logic [7:0] mem[8];
    logic [7:0] ref_gpr[8];
    bit         err_model = 1'b0;
    bit         resp_en = 1'b1;
    bit         force_done = 1'b0;
    int         wr_total = 0;
    int         total = 0;
    int         bad = 0;
    int         cyc = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // GPR file: registered read data, write on writeEn
    initial begin
        bus.gpr_regA_out = '0;
        bus.gpr_regB_out = '0;
        forever begin
            @(posedge clk);
            if (bus.gpr_readEn) begin
                bus.gpr_regA_out <= mem[bus.gpr_regA_num];
                bus.gpr_regB_out <= mem[bus.gpr_regB_num];
            end
            if (bus.gpr_writeEn) mem[bus.gpr_regC_num] <= bus.gpr_regC_in;
        end
    end

    // Execute unit: answers each start after the delay queued by the stimulus; strays done between ops
    initial begin
        int wait_left;
        int d;
        int p;
        bit stray_ok;
        wait_left = -1;
        stray_ok = 1'b1;
        bus.exec_done   = 1'b0;
        bus.exec_res_lo = '0;
        bus.exec_res_hi = '0;
        forever begin
            @(negedge clk);
            if (!resp_en) begin
                bus.exec_done = force_done;
                wait_left = -1;
            end else begin
                if (bus.exec_start) begin
                    stray_ok = 1'b0;
                    d = (dq.size() != 0) ? dq.pop_front() : NEVER;
                    wait_left = d;
                    if (bus.exec_is_mul) begin
                        p = int'(bus.exec_opA) * int'(bus.exec_opB);
                        bus.exec_res_lo = p[7:0];
                        bus.exec_res_hi = p[15:8];
                    end else begin
                        p = int'(bus.exec_opA) + int'(bus.exec_opB);
                        bus.exec_res_lo = p[7:0];
                        bus.exec_res_hi = 8'($urandom_range(0, 255));
                    end
                end
                if (wait_left == 0) begin
                    bus.exec_done = 1'b1;
                    wait_left = -1;
                end else begin
                    if (wait_left > 0) wait_left--;
                    bus.exec_done = stray_ok && ($urandom_range(0, 3) == 0);
                end
                if (bus.done) stray_ok = 1'b1;
            end
        end
    end

    // Monitor: per-operation activity counters, compared against the scoreboard on each done
    initial begin
        exp_t e;
        int rd_n, wr_n, st_n, mul_n, acc_n, acc_cyc;
        int ra, rb, wc, wlo, whi;
        rd_n = 0; wr_n = 0; st_n = 0; mul_n = 0; acc_n = 0; acc_cyc = 0;
        ra = 0; rb = 0; wc = 0; wlo = 0; whi = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                rd_n = 0; wr_n = 0; st_n = 0; mul_n = 0; acc_n = 0;
            end else begin
                if (bus.gpr_readEn) begin
                    rd_n++;
                    ra = int'(bus.gpr_regA_num);
                    rb = int'(bus.gpr_regB_num);
                end
                if (bus.gpr_writeEn) begin
                    wr_n++;
                    wr_total++;
                    wc  = int'(bus.gpr_regC_num);
                    wlo = int'(bus.gpr_regC_in);
                    whi = int'(bus.gpr_mulHighIn);
                end
                if (bus.exec_start) st_n++;
                if (bus.exec_is_mul) mul_n++;
                if (bus.done) begin
                    if (sc_q.size() == 0) begin
                        chk("unexpected_done", 1, 0);
                    end else begin
                        e = sc_q.pop_front();
                        chk("accepts_per_op", acc_n, 1);
                        chk("latency", cyc - acc_cyc, e.lat);
                        chk("readEn_count", rd_n, int'(e.rd));
                        if (e.rd) begin
                            chk("regA_num", ra, e.a);
                            chk("regB_num", rb, e.b);
                        end
                        chk("start_count", st_n, int'(e.st));
                        chk("writeEn_count", wr_n, int'(e.wb));
                        if (e.wb) begin
                            chk("regC_num", wc, e.c);
                            chk("regC_in", wlo, e.lo);
                            chk("mulHighIn", whi, e.hi);
                        end
                        chk("exec_err", int'(bus.exec_err), int'(e.err));
                        chk("is_mul_cycles", mul_n, e.mulcyc);
                        if (e.chk_op) begin
                            chk("exec_opA", int'(bus.exec_opA), e.oa);
                            chk("exec_opB", int'(bus.exec_opB), e.ob);
                        end
                        chk("busy_at_done", int'(bus.busy), 1);
                        chk("ready_at_done", int'(bus.issue_ready), 0);
                    end
                    rd_n = 0; wr_n = 0; st_n = 0; mul_n = 0; acc_n = 0;
                end
                if (bus.issue_valid && bus.issue_ready) begin
                    acc_n++;
                    acc_cyc = cyc;
                end
            end
        end
    end

    // Called just after a posedge; returns just after the posedge at which the op was accepted.
    task automatic issue(input int op, input int a, input int b, input int c, input int d, input bit keep);
        exp_t e;
        int g;
        int p;
        int xcyc;
        bus.issue_op    = 2'(op);
        bus.issue_srcA  = 3'(a);
        bus.issue_srcB  = 3'(b);
        bus.issue_dst   = 3'(c);
        bus.issue_valid = 1'b1;
        g = 0;
        @(negedge clk);
        while (!bus.issue_ready && g < 100) begin
            @(negedge clk);
            g++;
        end
        if (!bus.issue_ready) begin
            chk("issue_wait", 0, 1);
            bus.issue_valid = 1'b0;
            return;
        end
        e = '{default: 0};
        e.rd = (op != 3);
        e.chk_op = (op != 3);
        e.a = a;
        e.b = b;
        e.oa = int'(ref_gpr[a]);
        e.ob = int'(ref_gpr[b]);
        xcyc = 0;
        if (op == 3) begin
            e.lat = 1;
        end else if (op == 2) begin
            e.lat = 3;
        end else begin
            e.st = 1'b1;
            dq.push_back(d);
            if (d == NEVER || d >= TIMEOUT) begin
                e.lat = 3 + TIMEOUT;
                err_model = 1'b1;
                xcyc = TIMEOUT;
            end else begin
                e.lat = 3 + d + 1;
                e.wb = 1'b1;
                e.c = c;
                xcyc = d + 1;
                if (op == 1) begin
                    p = e.oa * e.ob;
                    e.lo = p % 256;
                    e.hi = p / 256;
                end else begin
                    e.lo = (e.oa + e.ob) % 256;
                    e.hi = 0;
                end
                ref_gpr[c] = 8'(e.lo);
            end
            e.mulcyc = (op == 1) ? xcyc : 0;
        end
        e.err = err_model;
        sc_q.push_back(e);
        @(posedge clk);
        #1;
        if (!keep) bus.issue_valid = 1'b0;
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (sc_q.size() != 0 && g < 300) begin
            @(negedge clk);
            g++;
        end
        chk("drain", sc_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0;
        int r;
        int d;
        for (int i = 0; i < 8; i++) begin
            mem[i] = 8'($urandom_range(0, 255));
        end
        mem[1] = 8'h12;
        mem[2] = 8'h34;
        mem[4] = 8'h10;
        mem[5] = 8'h20;
        for (int i = 0; i < 8; i++) ref_gpr[i] = mem[i];
        bus.issue_valid = 1'b0;
        bus.issue_op    = '0;
        bus.issue_srcA  = '0;
        bus.issue_srcB  = '0;
        bus.issue_dst   = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_ready", int'(bus.issue_ready), 1);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_readEn", int'(bus.gpr_readEn), 0);
        chk("rst_writeEn", int'(bus.gpr_writeEn), 0);
        chk("rst_start", int'(bus.exec_start), 0);
        chk("rst_err", int'(bus.exec_err), 0);
        chk("rst_opA", int'(bus.exec_opA), 0);
        chk("rst_regC_in", int'(bus.gpr_regC_in), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // ALU then read-after-write on the result; MUL with delayed done
        issue(0, 1, 2, 3, 0, 1'b1);
        issue(0, 3, 3, 4, 0, 1'b0);
        issue(1, 4, 5, 6, 4, 1'b0);
        issue(2, 6, 1, 0, 0, 1'b0);
        issue(3, 0, 0, 0, 0, 1'b0);
        // done on the last allowed EXEC cycle, then a real timeout, then err stays sticky
        issue(0, 1, 2, 7, TIMEOUT - 1, 1'b0);
        issue(1, 2, 3, 0, NEVER, 1'b0);
        issue(0, 7, 1, 2, 2, 1'b0);

        for (int n = 0; n < 40; n++) begin
            r = int'($urandom_range(0, 9));
            if (r < 7)       d = int'($urandom_range(0, 5));
            else if (r == 7) d = TIMEOUT - 1;
            else if (r == 8) d = NEVER;
            else             d = int'($urandom_range(6, 13));
            issue(int'($urandom_range(0, 3)), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                  int'($urandom_range(0, 7)), d, bit'($urandom_range(0, 1)));
        end
        bus.issue_valid = 1'b0;
        drain();

        // Reset during a MUL wait, then a late done must not cause a write
        resp_en = 1'b0;
        issue(1, 4, 5, 1, NEVER, 1'b0);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_ready", int'(bus.issue_ready), 1);
        chk("midrst_busy", int'(bus.busy), 0);
        chk("midrst_writeEn", int'(bus.gpr_writeEn), 0);
        chk("midrst_err", int'(bus.exec_err), 0);
        rst = 1'b0;
        sc_q.delete();
        dq.delete();
        err_model = 1'b0;
        w0 = wr_total;
        force_done = 1'b1;
        @(negedge clk);
        force_done = 1'b0;
        repeat (5) @(negedge clk);
        chk("late_done_writes", wr_total - w0, 0);
        chk("late_done_busy", int'(bus.busy), 0);
        resp_en = 1'b1;
        @(posedge clk);
        #1;
        issue(1, 4, 5, 2, 1, 1'b0);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
